// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 keyboard transmitter: FSM states,
// frame constants, odd parity and 11-bit frame assembly.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_BIT_HI,
    ST_BIT_LO,
    ST_GAP
  } ps2_state_e;

  localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
  localparam int         PS2_FRAME_BITS = 11;

  function automatic logic ps2_parity(input logic [7:0] code);
    return ~^code;
  endfunction

  // Bit 0 is the start bit, so shifting out from index 0 gives wire order.
  function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] code);
    return {1'b1, ps2_parity(code), code, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Synchronous FIFO with parameterized width and power-of-2 depth; the read
// data is the head entry, valid whenever empty is low.
module ps2_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             push, pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push    = wr_en & ~full;
  assign pop     = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 keyboard transmitter: queues scancodes and serializes each
// as an 11-bit frame. Define PS2_TX_BREAK_EN to send release entries as F0+code.
module ps2_kbd_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_code,
  input  logic       in_release,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic       tx_done
);

`ifdef PS2_TX_BREAK_EN
  localparam int ENTRY_W = 9;
`else
  localparam int ENTRY_W = 8;
`endif
  localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [3:0]       IDX_LAST = 4'(PS2_FRAME_BITS - 1);

  logic [ENTRY_W-1:0] wr_entry, rd_entry;
  logic               fifo_full, fifo_empty, pop, pop_release;

`ifdef PS2_TX_BREAK_EN
  assign wr_entry    = {in_release, in_code};
  assign pop_release = rd_entry[8];
`else
  logic unused_release;
  assign wr_entry       = in_code;
  assign pop_release    = 1'b0;
  assign unused_release = in_release;
`endif

  ps2_tx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (in_valid),
    .wr_data (wr_entry),
    .rd_en   (pop),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  ps2_state_e                state, state_d;
  logic [CNT_W-1:0]          cnt, cnt_d;
  logic [3:0]                idx, idx_d;
  logic [PS2_FRAME_BITS-1:0] frame_q, frame_d;
  logic [7:0]                code_q;
  // brk_q: popped entry still owes its F0 frame; hold_q: its code frame is next.
  logic                      brk_q, brk_d, hold_q, hold_d;
  logic                      ps2_clk_q, ps2_data_q, tx_done_q;
  logic                      ps2_clk_d, ps2_data_d, tx_done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      idx        <= '0;
      brk_q      <= 1'b0;
      hold_q     <= 1'b0;
      ps2_clk_q  <= 1'b1;
      ps2_data_q <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      idx        <= idx_d;
      brk_q      <= brk_d;
      hold_q     <= hold_d;
      ps2_clk_q  <= ps2_clk_d;
      ps2_data_q <= ps2_data_d;
      tx_done_q  <= tx_done_d;
    end
  end

  always_ff @(posedge clk) begin
    frame_q <= frame_d;
    if (pop) code_q <= rd_entry[7:0];
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    frame_d = frame_q;
    brk_d   = brk_q;
    hold_d  = hold_q;
    pop     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hold_q) begin
          state_d = ST_LOAD;
        end else if (!fifo_empty) begin
          pop     = 1'b1;
          brk_d   = pop_release;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        frame_d = ps2_frame(brk_q ? PS2_BREAK_CODE : code_q);
        hold_d  = brk_q;
        brk_d   = 1'b0;
        idx_d   = '0;
        cnt_d   = '0;
        state_d = ST_BIT_HI;
      end
      ST_BIT_HI: begin
        if (cnt == DIV_LAST) begin
          cnt_d   = '0;
          state_d = ST_BIT_LO;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      ST_BIT_LO: begin
        if (cnt == DIV_LAST) begin
          cnt_d = '0;
          if (idx == IDX_LAST) begin
            state_d = ST_GAP;
          end else begin
            idx_d   = idx + 1'b1;
            state_d = ST_BIT_HI;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered lines line up
  // with the state they belong to.
  always_comb begin
    ps2_clk_d  = (state_d != ST_BIT_LO);
    ps2_data_d = 1'b1;
    if (state_d == ST_BIT_HI || state_d == ST_BIT_LO) ps2_data_d = frame_d[idx_d];
    tx_done_d  = (state == ST_BIT_LO) && (state_d == ST_GAP);
  end

  assign ps2_clk  = ps2_clk_q;
  assign ps2_data = ps2_data_q;
  assign tx_done  = tx_done_q;
  assign in_ready = ~fifo_full;
  assign busy     = (state != ST_IDLE) | ~fifo_empty | hold_q;

endmodule
